rl_lj_pair_arbiter: RTL and testbench
=====================================

# rl_lj_pair_arbiter

Round-robin scheduler that shares one range-limited LJ force evaluation pipeline among NUM_REQ pair-filter requesters. Accepts at most one particle pair (r2, p_a, p_b) per cycle and issues it to the pipeline. Carries the requester ID through a fixed-latency tag delay line so each returned force is routed to its requester. Provides a drain handshake so the force-accumulation stage can quiesce the pipeline between cells.

## Interface

Parameters:
- DATA_WIDTH, 32, width of the IEEE-754 single-precision operands and result.
- NUM_REQ, 4, number of requesters (≥2).
- SRC_WIDTH, 2, requester-ID width; must satisfy 2^SRC_WIDTH ≥ NUM_REQ.
- PIPE_LATENCY, 59, fixed number of cycles from pipe_r2_valid to the matching pipe_force.
- CNT_WIDTH, 7, in-flight counter width; must satisfy 2^CNT_WIDTH > PIPE_LATENCY+2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester pair valid.
- req_r2  in  NUM_REQ*DATA_WIDTH  packed r2; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_p_a  in  NUM_REQ*DATA_WIDTH  packed LJ coefficient A.
- req_p_b  in  NUM_REQ*DATA_WIDTH  packed LJ coefficient B.
- req_ready  out  NUM_REQ  one-hot (or zero) grant, combinational.
- pipe_r2  out  DATA_WIDTH  registered operand to the pipeline.
- pipe_p_a  out  DATA_WIDTH  registered operand.
- pipe_p_b  out  DATA_WIDTH  registered operand.
- pipe_r2_valid  out  1  registered issue strobe.
- pipe_force  in  DATA_WIDTH  pipeline result.
- force_out  out  DATA_WIDTH  registered routed force.
- force_valid  out  1  registered strobe for force_out.
- force_src  out  SRC_WIDTH  requester ID of force_out.
- drain_req  in  1  level request to stop issuing and empty the pipeline.
- drain_done  out  1  high while drained.
- busy  out  1  high when inflight_cnt ≠ 0.
- inflight_cnt  out  CNT_WIDTH  pairs issued but not yet returned.

## Operation

- Transfer from requester i occurs on a cycle with req_valid[i] && req_ready[i]; at most one per cycle.
- Grant enable: state==RUN && !drain_req. When disabled, req_ready = 0.
- Arbitration: search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester is granted. After a grant to i, rr_ptr = (i+1) mod NUM_REQ. rr_ptr holds when there is no grant. Reset value is 0.
- Issue register: on a transfer, the pipe_* operands load the granted slices and pipe_r2_valid = 1. Otherwise pipe_r2_valid = 0 and the operands hold.
- Tag line: a PIPE_LATENCY-deep shift register of {valid, src} loaded with {pipe_r2_valid, src of the issued pair}. Its tail is time-aligned with pipe_force.
- Output register: force_valid = tail.valid, force_src = tail.src, force_out = pipe_force. When tail.valid = 0, force_out and force_src hold.
- The pipeline is instantiated with its enables tied high and cannot stall. There is no output backpressure; consumers must accept every force_valid.
- inflight_cnt: +1 on transfer, −1 on force_valid, unchanged when both occur in the same cycle. The maximum is PIPE_LATENCY+2. busy = (inflight_cnt ≠ 0).
- State machine:
  - RUN → DRAIN when drain_req = 1.
  - DRAIN → DRAINED when inflight_cnt = 0.
  - DRAINED → RUN when drain_req = 0.
  - DRAIN → RUN if drain_req drops before the count reaches 0.
- drain_done = (state==DRAINED), registered.
- Reset values: every output 0, state RUN, tag line all-invalid, rr_ptr 0.
- Reset asserted mid-stream discards all in-flight tags. No force_valid may appear for pairs issued before reset, even though the pipeline still emits data.

## Timing

- Transfer in cycle T:
  - pipe_r2_valid high in T+1.
  - pipe_force valid in T+1+PIPE_LATENCY.
  - force_valid high in T+2+PIPE_LATENCY; with the default parameters this is T+61.
- Sustained throughput is one pair per cycle. Output order equals issue order.
- req_ready depends combinationally on req_valid, rr_ptr, state and drain_req. No requester may make req_valid depend on req_ready.
- drain_req asserted in cycle T blocks grants from T onward, combinationally.
- drain_done rises the cycle after inflight_cnt reaches 0 in DRAIN.

## Configuration

- RL_LJ_ARB_STATS_EN defined adds three ports:
  - stat_clr (in, 1): synchronous clear of both counters.
  - stat_issue_cnt (out, 32): total transfers.
  - stat_idle_cnt (out, 32): RUN cycles with req_valid = 0.
  - Both counters saturate at all-ones and reset to 0 on rst.
- Without RL_LJ_ARB_STATS_EN, these ports and their counters are absent. Core behaviour is identical in both builds.

## Test plan

- Single pair: requester 2 presents r2=0x3F800000, p_a=0x40000000, p_b=0x3F000000 at T.
  - req_ready=4'b0100 at T.
  - pipe_r2_valid at T+1 with those operands.
  - force_valid at T+61 with force_src=2; inflight_cnt returns to 0.
- All four requesters continuously valid from reset: grants rotate 0,1,2,3,0,… every cycle; inflight_cnt saturates at 61; force_src sequence matches the grant order.
- Fairness: only requesters 1 and 3 valid with rr_ptr=0 → grants alternate 1,3,1,3; no requester waits more than NUM_REQ−1 cycles.
- Drain: 10 pairs issued, then drain_req=1.
  - req_ready=0 immediately; exactly 10 force_valid pulses.
  - drain_done high one cycle after inflight_cnt hits 0.
  - Deasserting drain_req returns the block to RUN and grants resume.
- Reset mid-stream: rst pulsed 20 cycles after 5 issues → all outputs 0 and no force_valid for the next 70 cycles with requests idle.
- With RL_LJ_ARB_STATS_EN: 8 transfers and 12 idle RUN cycles → stat_issue_cnt=8 and stat_idle_cnt=12; stat_clr → both read 0 the next cycle.

Source files
------------

// File: rtl/rl_lj_pair_arbiter_if.sv
// rtl/rl_lj_pair_arbiter_if.sv - bundle of requester, pipeline, force and drain signals for rl_lj_pair_arbiter
// Ports (signals):
//   req_valid/req_r2/req_p_a/req_p_b/req_ready  requester handshake, packed per requester
//   pipe_r2/pipe_p_a/pipe_p_b/pipe_r2_valid     issue to the LJ force pipeline
//   pipe_force                                  pipeline result
//   force_out/force_valid/force_src             routed force
//   drain_req/drain_done/busy/inflight_cnt      drain handshake and status
// Modports: slave = arbiter side, master = requesters/pipeline/accumulator side.
interface rl_lj_pair_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int SRC_WIDTH  = 2,
  parameter int CNT_WIDTH  = 7
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_r2;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_p_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_p_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         pipe_r2;
  logic [DATA_WIDTH-1:0]         pipe_p_a;
  logic [DATA_WIDTH-1:0]         pipe_p_b;
  logic                          pipe_r2_valid;
  logic [DATA_WIDTH-1:0]         pipe_force;
  logic [DATA_WIDTH-1:0]         force_out;
  logic                          force_valid;
  logic [SRC_WIDTH-1:0]          force_src;
  logic                          drain_req;
  logic                          drain_done;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          inflight_cnt;

  modport slave (
    input  req_valid, req_r2, req_p_a, req_p_b, pipe_force, drain_req,
    output req_ready, pipe_r2, pipe_p_a, pipe_p_b, pipe_r2_valid,
           force_out, force_valid, force_src, drain_done, busy, inflight_cnt
  );

  modport master (
    output req_valid, req_r2, req_p_a, req_p_b, pipe_force, drain_req,
    input  req_ready, pipe_r2, pipe_p_a, pipe_p_b, pipe_r2_valid,
           force_out, force_valid, force_src, drain_done, busy, inflight_cnt
  );
endinterface

// File: rtl/rl_lj_pair_arbiter.sv
// rtl/rl_lj_pair_arbiter.sv - round-robin pair scheduler for a shared fixed-latency LJ force pipeline
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rl_lj_pair_arbiter_if.slave: requester handshake, pipeline issue/return,
//        routed force output, drain handshake, busy and inflight_cnt status
// Optional build macro RL_LJ_ARB_STATS_EN adds:
//   stat_clr (in), stat_issue_cnt (out, 32), stat_idle_cnt (out, 32), saturating counters
module rl_lj_pair_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int SRC_WIDTH    = 2,
  parameter int PIPE_LATENCY = 59,
  parameter int CNT_WIDTH    = 7
) (
  input  logic                clk,
  input  logic                rst,
  rl_lj_pair_arbiter_if.slave bus
`ifdef RL_LJ_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         stat_issue_cnt,
  output logic [31:0]         stat_idle_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

  state_t                 state;
  logic                   drain_done_r;
  logic [SRC_WIDTH-1:0]   rr_ptr;
  logic                   grant_en;
  logic [NUM_REQ-1:0]     grant;
  logic [SRC_WIDTH-1:0]   grant_src;
  logic [SRC_WIDTH-1:0]   next_ptr;
  logic                   xfer;
  int                     arb_idx;
  logic                   arb_found;
  logic [DATA_WIDTH-1:0]  sel_r2, sel_p_a, sel_p_b;

  logic [DATA_WIDTH-1:0]  pipe_r2_r, pipe_p_a_r, pipe_p_b_r;
  logic                   pipe_v_r;
  logic [SRC_WIDTH-1:0]   pipe_src_r;

  // Requester ID travels alongside the pipeline; the tail lines up with pipe_force.
  logic                   tag_v   [PIPE_LATENCY];
  logic [SRC_WIDTH-1:0]   tag_src [PIPE_LATENCY];

  logic [DATA_WIDTH-1:0]  force_out_r;
  logic                   force_valid_r;
  logic [SRC_WIDTH-1:0]   force_src_r;
  logic [CNT_WIDTH-1:0]   inflight;

  assign grant_en = (state == ST_RUN) && !bus.drain_req;

  // Scan NUM_REQ positions starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_src = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!arb_found && grant_en && (i == arb_idx) && bus.req_valid[i]) begin
          arb_found = 1'b1;
          grant[i]  = 1'b1;
          grant_src = SRC_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    sel_r2  = '0;
    sel_p_a = '0;
    sel_p_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_r2  = bus.req_r2 [i*DATA_WIDTH +: DATA_WIDTH];
        sel_p_a = bus.req_p_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_p_b = bus.req_p_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer     = |grant;
  assign next_ptr = (grant_src == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant_src + SRC_WIDTH'(1);

  // Issue register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_r2_r  <= '0;
      pipe_p_a_r <= '0;
      pipe_p_b_r <= '0;
      pipe_v_r   <= 1'b0;
      pipe_src_r <= '0;
      rr_ptr     <= '0;
    end else begin
      pipe_v_r <= xfer;
      if (xfer) begin
        pipe_r2_r  <= sel_r2;
        pipe_p_a_r <= sel_p_a;
        pipe_p_b_r <= sel_p_b;
        pipe_src_r <= grant_src;
        rr_ptr     <= next_ptr;
      end
    end
  end

  // Tag delay line; clearing it on reset is what suppresses forces of pre-reset pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_v[i]   <= 1'b0;
        tag_src[i] <= '0;
      end
    end else begin
      tag_v[0]   <= pipe_v_r;
      tag_src[0] <= pipe_src_r;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  // Routed force output and in-flight accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_out_r   <= '0;
      force_valid_r <= 1'b0;
      force_src_r   <= '0;
      inflight      <= '0;
    end else begin
      force_valid_r <= tag_v[PIPE_LATENCY-1];
      if (tag_v[PIPE_LATENCY-1]) begin
        force_out_r <= bus.pipe_force;
        force_src_r <= tag_src[PIPE_LATENCY-1];
      end
      if (xfer && !force_valid_r)
        inflight <= inflight + CNT_WIDTH'(1);
      else if (!xfer && force_valid_r)
        inflight <= inflight - CNT_WIDTH'(1);
    end
  end

  // Drain FSM; drain_done is registered together with the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      drain_done_r <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          drain_done_r <= 1'b0;
          if (bus.drain_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // An empty pipeline wins over a simultaneous drain_req drop.
          if (inflight == '0) begin
            state        <= ST_DRAINED;
            drain_done_r <= 1'b1;
          end else if (!bus.drain_req) begin
            state        <= ST_RUN;
            drain_done_r <= 1'b0;
          end
        end
        ST_DRAINED: begin
          if (!bus.drain_req) begin
            state        <= ST_RUN;
            drain_done_r <= 1'b0;
          end
        end
        default: begin
          state        <= ST_RUN;
          drain_done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef RL_LJ_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue_cnt <= '0;
      stat_idle_cnt  <= '0;
    end else if (stat_clr) begin
      stat_issue_cnt <= '0;
      stat_idle_cnt  <= '0;
    end else begin
      if (xfer && (stat_issue_cnt != '1))
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if ((state == ST_RUN) && (bus.req_valid == '0) && (stat_idle_cnt != '1))
        stat_idle_cnt <= stat_idle_cnt + 32'd1;
    end
  end
`endif

  assign bus.req_ready     = grant;
  assign bus.pipe_r2       = pipe_r2_r;
  assign bus.pipe_p_a      = pipe_p_a_r;
  assign bus.pipe_p_b      = pipe_p_b_r;
  assign bus.pipe_r2_valid = pipe_v_r;
  assign bus.force_out     = force_out_r;
  assign bus.force_valid   = force_valid_r;
  assign bus.force_src     = force_src_r;
  assign bus.drain_done    = drain_done_r;
  assign bus.busy          = (inflight != '0);
  assign bus.inflight_cnt  = inflight;

endmodule

// File: tb/tb_rl_lj_pair_arbiter.sv
// tb/tb_rl_lj_pair_arbiter.sv - self-checking bench for rl_lj_pair_arbiter
module tb_rl_lj_pair_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int SW = 2;
  localparam int PL = 59;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rl_lj_pair_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .SRC_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

`ifdef RL_LJ_ARB_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_issue_cnt, stat_idle_cnt;
`endif

  rl_lj_pair_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .SRC_WIDTH(SW), .PIPE_LATENCY(PL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RL_LJ_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_issue_cnt(stat_issue_cnt),
    .stat_idle_cnt(stat_idle_cnt)
`endif
  );

  // Stand-in for the force pipeline: fixed latency, never stalls, ignores reset.
  function automatic logic [DW-1:0] pf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [DW-1:0] c);
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  logic [DW-1:0] stage [PL];
  always @(posedge clk) begin
    stage[0] <= pf(bus.pipe_r2, bus.pipe_p_a, bus.pipe_p_b);
    for (int i = 1; i < PL; i++) stage[i] <= stage[i-1];
  end
  assign bus.pipe_force = stage[PL-1];

  // Reference model: list of issued pairs; everything else derives from issue cycles.
  typedef struct {
    int            t;
    logic [SW-1:0] src;
    logic [DW-1:0] r2, pa, pb;
  } iss_t;

  typedef struct {
    logic [NR-1:0] valid;
    logic          drain;
    logic [NR-1:0] exp_ready;
  } vec_t;

  iss_t q[$];
  int   now, rr, mode;          // mode: 0 run, 1 drain, 2 drained
  logic [DW-1:0] last_r2, last_pa, last_pb, last_fout;
  logic [SW-1:0] last_fsrc;
  int   total, bad;
  int   fv_count, last_fv_cycle, max_cnt, xfer_count;
  logic [SW-1:0] last_fv_src;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic d);
    bus.req_valid = v;
    bus.drain_req = d;
    for (int i = 0; i < NR; i++) begin
      bus.req_r2 [i*DW +: DW] = $urandom();
      bus.req_p_a[i*DW +: DW] = $urandom();
      bus.req_p_b[i*DW +: DW] = $urandom();
    end
  endtask

  task automatic model_step();
    int cnt, g;
    logic en, fv_exp, pv_exp;
    logic [NR-1:0] exp_rdy;
    iss_t e;
    while (q.size() > 0 && q[0].t + PL + 2 < now) void'(q.pop_front());
    cnt = q.size();
    chk("inflight_cnt", 64'(bus.inflight_cnt), 64'(cnt));
    chk("busy", 64'(bus.busy), 64'(cnt != 0));
    fv_exp = (cnt > 0) && (q[0].t + PL + 2 == now);
    chk("force_valid", 64'(bus.force_valid), 64'(fv_exp));
    if (fv_exp) begin
      last_fsrc = q[0].src;
      last_fout = pf(q[0].r2, q[0].pa, q[0].pb);
    end
    chk("force_src", 64'(bus.force_src), 64'(last_fsrc));
    chk("force_out", 64'(bus.force_out), 64'(last_fout));
    pv_exp = (cnt > 0) && (q[cnt-1].t == now - 1);
    chk("pipe_r2_valid", 64'(bus.pipe_r2_valid), 64'(pv_exp));
    chk("pipe_r2", 64'(bus.pipe_r2), 64'(last_r2));
    chk("pipe_p_a", 64'(bus.pipe_p_a), 64'(last_pa));
    chk("pipe_p_b", 64'(bus.pipe_p_b), 64'(last_pb));
    chk("drain_done", 64'(bus.drain_done), 64'(mode == 2));

    en = (mode == 0) && !bus.drain_req;
    g  = -1;
    if (en) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (rr + k) % NR;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    end
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

    if (bus.force_valid) begin
      fv_count++;
      last_fv_cycle = now;
      last_fv_src   = bus.force_src;
    end
    if (int'(bus.inflight_cnt) > max_cnt) max_cnt = int'(bus.inflight_cnt);

    if (g >= 0) begin
      e.t   = now;
      e.src = SW'(g);
      e.r2  = bus.req_r2 [g*DW +: DW];
      e.pa  = bus.req_p_a[g*DW +: DW];
      e.pb  = bus.req_p_b[g*DW +: DW];
      q.push_back(e);
      last_r2 = e.r2; last_pa = e.pa; last_pb = e.pb;
      rr = (g + 1) % NR;
      xfer_count++;
    end

    case (mode)
      0: if (bus.drain_req) mode = 1;
      1: if (cnt == 0) mode = 2; else if (!bus.drain_req) mode = 0;
      default: if (!bus.drain_req) mode = 0;
    endcase
  endtask

  task automatic tick();
    #2;
    model_step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic do_reset();
    drive('0, 1'b0);
    rst = 1'b1;
    #2;
    chk("rst_pipe_r2_valid", 64'(bus.pipe_r2_valid), 64'd0);
    chk("rst_pipe_r2", 64'(bus.pipe_r2), 64'd0);
    chk("rst_force_valid", 64'(bus.force_valid), 64'd0);
    chk("rst_force_out", 64'(bus.force_out), 64'd0);
    chk("rst_force_src", 64'(bus.force_src), 64'd0);
    chk("rst_drain_done", 64'(bus.drain_done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_inflight", 64'(bus.inflight_cnt), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
`ifdef RL_LJ_ARB_STATS_EN
    chk("rst_stat_issue", 64'(stat_issue_cnt), 64'd0);
    chk("rst_stat_idle", 64'(stat_idle_cnt), 64'd0);
`endif
    q.delete();
    rr = 0; mode = 0;
    last_r2 = '0; last_pa = '0; last_pb = '0; last_fout = '0; last_fsrc = '0;
    fv_count = 0; max_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    now++;
  endtask

  vec_t vecs [12];
  int   t0, zero_cyc, done_cyc, xc0;
  logic d;

  initial begin
    total = 0; bad = 0; now = 0; xfer_count = 0;
    last_fv_cycle = -1; last_fv_src = '0;
`ifdef RL_LJ_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    vecs[0]  = '{4'b1010, 1'b0, 4'b0010};
    vecs[1]  = '{4'b1010, 1'b0, 4'b1000};
    vecs[2]  = '{4'b1010, 1'b0, 4'b0010};
    vecs[3]  = '{4'b1010, 1'b0, 4'b1000};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0100, 1'b0, 4'b0100};
    vecs[6]  = '{4'b0011, 1'b0, 4'b0001};
    vecs[7]  = '{4'b0011, 1'b0, 4'b0010};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0000};
    vecs[10] = '{4'b1111, 1'b0, 4'b0100};
    vecs[11] = '{4'b1000, 1'b0, 4'b1000};

    do_reset();

    // Fairness, hold, wrap and drain-abort vectors
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].valid, vecs[v].drain);
      #1;
      chk("vec_ready", 64'(bus.req_ready), 64'(vecs[v].exp_ready));
      tick();
    end

    // Single pair from requester 2
    do_reset();
    drive(4'b0100, 1'b0);
    bus.req_r2 [2*DW +: DW] = 32'h3F80_0000;
    bus.req_p_a[2*DW +: DW] = 32'h4000_0000;
    bus.req_p_b[2*DW +: DW] = 32'h3F00_0000;
    t0 = now;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    drive('0, 1'b0);
    chk("single_pv", 64'(bus.pipe_r2_valid), 64'd1);
    chk("single_r2", 64'(bus.pipe_r2), 64'h3F80_0000);
    chk("single_pa", 64'(bus.pipe_p_a), 64'h4000_0000);
    chk("single_pb", 64'(bus.pipe_p_b), 64'h3F00_0000);
    for (int c = 0; c < 70; c++) tick();
    chk("single_latency", 64'(last_fv_cycle - t0), 64'd61);
    chk("single_src", 64'(last_fv_src), 64'd2);
    chk("single_count", 64'(fv_count), 64'd1);
    chk("single_inflight", 64'(bus.inflight_cnt), 64'd0);

    // All requesters continuously valid
    do_reset();
    for (int c = 0; c < 90; c++) begin
      drive(4'b1111, 1'b0);
      if (c < 8) begin
        #1;
        chk("rotate_ready", 64'(bus.req_ready), 64'(1 << (c % 4)));
      end
      tick();
    end
    chk("max_inflight", 64'(max_cnt), 64'd61);
    drive('0, 1'b0);
    for (int c = 0; c < 65; c++) tick();

    // Drain after 10 issues
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(4'b0001, 1'b0);
      tick();
    end
    zero_cyc = -1; done_cyc = -1;
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      drive(4'b1111, 1'b1);
      if (zero_cyc < 0 && bus.inflight_cnt == '0) zero_cyc = now;
      if (done_cyc < 0 && bus.drain_done) done_cyc = now;
      tick();
    end
    chk("drain_done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("drain_pulses", 64'(fv_count), 64'd10);
    chk("drain_done_delay", 64'(done_cyc - zero_cyc), 64'd1);
    xc0 = xfer_count;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b0);
      tick();
    end
    chk("drain_resume", 64'(xfer_count - xc0 >= 3), 64'd1);

    // Reset in the middle of a stream
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b0);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      drive('0, 1'b0);
      tick();
    end
    do_reset();
    for (int c = 0; c < 70; c++) tick();
    chk("post_reset_no_force", 64'(fv_count), 64'd0);

    // Randomized traffic with occasional drain requests
    do_reset();
    d = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) d = !d;
      drive(4'($urandom_range(0, 15)), d);
      tick();
    end
    drive('0, 1'b0);
    for (int c = 0; c < 70; c++) tick();

`ifdef RL_LJ_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'b0001, 1'b0);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      drive('0, 1'b0);
      tick();
    end
    chk("stat_issue", 64'(stat_issue_cnt), 64'd8);
    chk("stat_idle", 64'(stat_idle_cnt), 64'd12);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_issue_clr", 64'(stat_issue_cnt), 64'd0);
    chk("stat_idle_clr", 64'(stat_idle_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", now);
    $fatal(1);
  end

endmodule
